// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, types and helpers for the I2S transmitter.
//   FRAME_LEN  clk cycles per stereo frame (one LRCLK period)
//   SCLK_DIV   clk cycles per serial bit
//   SLOT_BITS  serial bits per channel slot
//   MCLK_DIV   clk cycles per MCLK period
//   stereo_t   left/right sample pair, samples held right-aligned in MAX_WIDTH bits
//   slot_bit() serial bit for bit position p of a slot sample
package audio_pkg;

  localparam int unsigned FRAME_LEN = 512;
  localparam int unsigned SCLK_DIV  = 8;
  localparam int unsigned SLOT_BITS = 32;
  localparam int unsigned MCLK_DIV  = 2;
  localparam int unsigned MAX_WIDTH = 24;

  localparam int unsigned CNT_W    = $clog2(FRAME_LEN);     // frame counter width
  localparam int unsigned BIT_LSB  = $clog2(SCLK_DIV);      // lowest cnt bit of bit position
  localparam int unsigned POS_W    = $clog2(SLOT_BITS);     // bit position width
  localparam int unsigned MCLK_BIT = $clog2(MCLK_DIV) - 1;
  localparam int unsigned SCLK_BIT = BIT_LSB - 1;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] l;
    logic [MAX_WIDTH-1:0] r;
  } stereo_t;

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_t;

  // I2S: one-bit delay, MSB at p = 1. Left-justified: MSB at p = 0.
  // Positions past the sample width are zero.
  function automatic logic slot_bit(input logic [MAX_WIDTH-1:0] s,
                                    input logic [POS_W-1:0]     p,
                                    input int unsigned          width,
                                    input logic                 lj);
    int unsigned pi;
    slot_bit = 1'b0;
    pi = 32'(p);
    if (lj) begin
      if (pi < width) slot_bit = s[5'(width - 1 - pi)];
    end else begin
      if (pi >= 1 && pi <= width) slot_bit = s[5'(width - pi)];
    end
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// audio_clk_gen: lock synchronizer, frame counter and registered audio clocks.
//   clk        24.576 MHz audio clock
//   rst        asynchronous active-high reset
//   pll_locked PLL lock (asynchronous), synchronized to run
//   cnt        frame counter, 0..FRAME_LEN-1, held at 0 while not running
//   run        synchronized lock
//   frame_load strobe on the last cycle of a frame
//   mclk/sclk/lrclk registered clock outputs, forced low while not running
// Macro AUDIO_I2S_LJ_EN: left-justified build, lrclk high during the left slot.
module audio_clk_gen
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic [CNT_W-1:0] cnt,
  output logic             run,
  output logic             frame_load,
  output logic             mclk,
  output logic             sclk,
  output logic             lrclk
);

`ifdef AUDIO_I2S_LJ_EN
  localparam logic LR_INV = 1'b1;
`else
  localparam logic LR_INV = 1'b0;
`endif

  logic lock_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      run       <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      run       <= lock_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (!run) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign frame_load = run && (cnt == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mclk  <= 1'b0;
      sclk  <= 1'b0;
      lrclk <= 1'b0;
    end else begin
      mclk  <= run & cnt[MCLK_BIT];
      sclk  <= run & cnt[SCLK_BIT];
      lrclk <= run & (cnt[CNT_W-1] ^ LR_INV);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo I2S transmitter with a one-entry sample holding buffer.
//   clk, rst          24.576 MHz audio clock, asynchronous active-high reset
//   pll_locked        PLL lock (asynchronous)
//   sample_l/r        two's complement samples, WIDTH bits (8..24)
//   sample_valid      pair offered; accepted when sample_ready is high
//   sample_ready      buffer empty and block running
//   mclk/sclk/lrclk   clk/2, clk/8, clk/512
//   sdata             serial data, MSB first, changes with sclk falling
//   underrun          one-cycle pulse when a frame starts with no new pair
// Macro AUDIO_I2S_LJ_EN: left-justified format (MSB at p = 0, lrclk = 1 for left).
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             mclk,
  output logic             sclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

`ifdef AUDIO_I2S_LJ_EN
  localparam logic LJ_MODE = 1'b1;
`else
  localparam logic LJ_MODE = 1'b0;
`endif

  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             frame_load;
  logic             accept;
  buf_state_t       buf_state, buf_next;
  stereo_t          buf_q, cur_q, in_pair;

  audio_clk_gen u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .cnt        (cnt),
    .run        (run),
    .frame_load (frame_load),
    .mclk       (mclk),
    .sclk       (sclk),
    .lrclk      (lrclk)
  );

  always_comb begin
    in_pair   = '0;
    in_pair.l = MAX_WIDTH'(sample_l);
    in_pair.r = MAX_WIDTH'(sample_r);
  end

  assign sample_ready = run && (buf_state == BUF_EMPTY);
  assign accept       = sample_valid && sample_ready;

  // An accept on the frame-load cycle bypasses the buffer, so it stays empty.
  always_comb begin
    buf_next = buf_state;
    if (!run) begin
      buf_next = BUF_EMPTY;
    end else begin
      case (buf_state)
        BUF_EMPTY: if (accept && !frame_load) buf_next = BUF_FULL;
        BUF_FULL:  if (frame_load)            buf_next = BUF_EMPTY;
        default:                              buf_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_state <= BUF_EMPTY;
    else     buf_state <= buf_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      cur_q    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_load && (buf_state == BUF_EMPTY) && !accept;
      if (accept && !frame_load) buf_q <= in_pair;
      if (frame_load) begin
        if (buf_state == BUF_FULL) cur_q <= buf_q;
        else if (accept)           cur_q <= in_pair;
      end
    end
  end

  // Updated once per serial bit, on the cycle the low counter bits are zero,
  // which lines the registered output up with the registered sclk falling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdata <= 1'b0;
    end else if (!run) begin
      sdata <= 1'b0;
    end else if (cnt[BIT_LSB-1:0] == '0) begin
      sdata <= slot_bit(cnt[CNT_W-1] ? cur_q.r : cur_q.l,
                        cnt[CNT_W-2:BIT_LSB], WIDTH, LJ_MODE);
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

  localparam int unsigned WIDTH = 16;
`ifdef AUDIO_I2S_LJ_EN
  localparam bit LJ = 1'b1;
  localparam logic [31:0] EXP_L1 = 32'hA5C3_0000;
  localparam logic [31:0] EXP_R1 = 32'h1234_0000;
  localparam logic [31:0] EXP_L2 = 32'h8001_0000;
  localparam logic [31:0] EXP_R2 = 32'h7FFE_0000;
`else
  localparam bit LJ = 1'b0;
  localparam logic [31:0] EXP_L1 = 32'h52E1_8000;
  localparam logic [31:0] EXP_R1 = 32'h091A_0000;
  localparam logic [31:0] EXP_L2 = 32'h4000_8000;
  localparam logic [31:0] EXP_R2 = 32'h3FFF_0000;
`endif

  logic clk = 1'b0;
  logic rst, pll_locked, sample_valid;
  logic [WIDTH-1:0] sample_l, sample_r;
  logic sample_ready, mclk, sclk, lrclk, sdata, underrun;

  audio_i2s_tx #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mclk         (mclk),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Reference model: frame phase since lock, a one-deep pending queue and the
  // pair currently being played. Expected registered outputs follow from the
  // phase of the previous cycle by plain arithmetic.
  int                 m_phase;
  bit                 m_s1, m_run;
  logic [WIDTH-1:0]   m_l, m_r;
  logic [2*WIDTH-1:0] m_q[$];
  bit e_mclk, e_sclk, e_lrclk, e_sdata, e_under;

  function automatic bit model_bit(int phase);
    int p;
    logic [WIDTH-1:0] s, t;
    p = (phase % 256) / 8;
    s = (phase >= 256) ? m_r : m_l;
    if (LJ) begin
      if (p >= WIDTH) return 1'b0;
      t = s >> (WIDTH - 1 - p);
    end else begin
      if (p < 1 || p > WIDTH) return 1'b0;
      t = s >> (WIDTH - p);
    end
    return t[0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_run = 0; m_phase = 0; m_q.delete(); m_l = '0; m_r = '0;
      e_mclk = 0; e_sclk = 0; e_lrclk = 0; e_sdata = 0; e_under = 0;
    end else begin
      bit acc;
      acc     = sample_valid && m_run && (m_q.size() == 0);
      e_mclk  = m_run && (m_phase % 2 == 1);
      e_sclk  = m_run && ((m_phase / 4) % 2 == 1);
      e_lrclk = m_run && ((m_phase >= 256) != LJ);
      e_sdata = m_run && model_bit(m_phase);
      e_under = m_run && (m_phase == 511) && (m_q.size() == 0) && !acc;
      if (!m_run) begin
        m_phase = 0;
        m_q.delete();
      end else begin
        if (m_phase == 511) begin
          if (m_q.size() != 0) {m_l, m_r} = m_q.pop_front();
          else if (acc)        {m_l, m_r} = {sample_l, sample_r};
        end else if (acc) begin
          m_q.push_back({sample_l, sample_r});
        end
        m_phase = (m_phase + 1) % 512;
      end
      m_run = m_s1;
      m_s1  = pll_locked;
    end
  end

  always @(negedge clk) begin
    check("outputs{mclk,sclk,lrclk,sdata,underrun,ready}",
          32'({mclk, sclk, lrclk, sdata, underrun, sample_ready}),
          32'({e_mclk, e_sclk, e_lrclk, e_sdata, e_under, m_run && (m_q.size() == 0)}));
  end

  task automatic offer(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    int i = 0;
    while (!sample_ready && i < 1200) begin
      @(negedge clk);
      i++;
    end
    if (!sample_ready) timeout("offer_ready");
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int i = 0;
    while (!(m_run && m_phase == ph) && i < 1200) begin
      @(negedge clk);
      i++;
    end
    if (!(m_run && m_phase == ph)) timeout("wait_phase");
  endtask

  // Collects the 64 bits of the next frame, sampled on sclk rising.
  task automatic capture(output logic [31:0] lw, output logic [31:0] rw);
    bit left, prev_lr, prev_sc, started;
    int i, n;
    left = LJ; prev_lr = lrclk; started = 0; i = 0; n = 0;
    lw = '0; rw = '0;
    while (!started && i < 1200) begin
      @(negedge clk);
      i++;
      if (lrclk == left && prev_lr != left) started = 1;
      prev_lr = lrclk;
    end
    if (!started) begin
      timeout("capture_start");
      return;
    end
    prev_sc = sclk;
    i = 0;
    while (n < 64 && i < 600) begin
      @(negedge clk);
      i++;
      if (sclk && !prev_sc) begin
        if (n < 32) lw = {lw[30:0], sdata};
        else        rw = {rw[30:0], sdata};
        n++;
      end
      prev_sc = sclk;
    end
    if (n < 64) timeout("capture_bits");
  endtask

  initial begin
    logic [31:0] lw, rw;
    int nz, uc, mh, sh, lh, mr, sf, lr;
    bit found, pm, ps, pl;

    rst = 1'b1; pll_locked = 1'b0; sample_valid = 1'b0;
    sample_l = '0; sample_r = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({mclk, sclk, lrclk, sdata, underrun, sample_ready}), 32'd0);
    rst = 1'b0;

    // Lock gating
    nz = 0;
    repeat (100) begin
      @(negedge clk);
      if ({mclk, sclk, lrclk, sdata, underrun, sample_ready} != 6'd0) nz++;
    end
    check("unlocked_quiet_cycles", nz, 0);
    pll_locked = 1'b1;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (mclk) found = 1;
    end
    if (!found) timeout("lock_start_mclk");
    check("lock_start_ready", 32'(sample_ready), 32'd1);

    // Clock ratios over 2048 cycles
    mh = 0; sh = 0; lh = 0; mr = 0; sf = 0; lr = 0;
    pm = mclk; ps = sclk; pl = lrclk;
    repeat (2048) begin
      @(negedge clk);
      mh += int'(mclk); sh += int'(sclk); lh += int'(lrclk);
      if (mclk && !pm)  mr++;
      if (!sclk && ps)  sf++;
      if (lrclk && !pl) lr++;
      pm = mclk; ps = sclk; pl = lrclk;
    end
    check("mclk_high_cycles", mh, 1024);
    check("sclk_high_cycles", sh, 1024);
    check("lrclk_high_cycles", lh, 1024);
    check("mclk_rises", mr, 1024);
    check("sclk_falls", sf, 256);
    check("lrclk_rises", lr, 4);

    // Serialization
    offer(16'hA5C3, 16'h1234);
    capture(lw, rw);
    check("ser_left_word", lw, EXP_L1);
    check("ser_right_word", rw, EXP_R1);

    // Underrun: nothing offered, previous pair repeats
    uc = 0;
    repeat (1024) begin
      @(negedge clk);
      uc += int'(underrun);
    end
    check("underrun_pulses_2frames", uc, 2);
    capture(lw, rw);
    check("repeat_left_word", lw, EXP_L1);
    check("repeat_right_word", rw, EXP_R1);

    // Boundary accept on the frame-load cycle with the buffer empty
    wait_phase(511);
    sample_l = 16'h8001; sample_r = 16'h7FFE; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("boundary_no_underrun", 32'(underrun), 32'd0);
    check("boundary_buffer_empty", 32'(sample_ready), 32'd1);
    capture(lw, rw);
    check("boundary_left_word", lw, EXP_L2);
    check("boundary_right_word", rw, EXP_R2);

    // Randomized traffic with occasional lock drops
    repeat (4000) begin
      @(negedge clk);
      sample_valid = 1'($urandom_range(0, 1));
      sample_l = WIDTH'($urandom);
      sample_r = WIDTH'($urandom);
      if ($urandom_range(0, 1499) == 0) pll_locked = ~pll_locked;
    end
    sample_valid = 1'b0;
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);

    // Mid-frame reset with the buffer full
    wait_phase(10);
    offer(16'h0F0F, 16'hF0F0);
    wait_phase(200);
    check("pre_reset_buffer_full", 32'(sample_ready), 32'd0);
    #2 rst = 1'b1;
    #1 check("midframe_reset_outputs",
             32'({mclk, sclk, lrclk, sdata, underrun, sample_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_buffer_empty", 32'(sample_ready), 32'd1);
    capture(lw, rw);
    check("post_reset_left_zero", lw, 32'd0);
    check("post_reset_right_zero", rw, 32'd0);

    // Lock drop with the buffer full
    wait_phase(10);
    offer(16'h3C3C, 16'hC3C3);
    check("pre_drop_buffer_full", 32'(sample_ready), 32'd0);
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    check("lock_drop_outputs",
          32'({mclk, sclk, lrclk, sdata, underrun, sample_ready}), 32'd0);
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    check("lock_resume_buffer_empty", 32'(sample_ready), 32'd1);

    repeat (1500) begin
      @(negedge clk);
      sample_valid = 1'($urandom_range(0, 1));
      sample_l = WIDTH'($urandom);
      sample_r = WIDTH'($urandom);
    end
    sample_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- I2S transmitter clocked from the 24.576 MHz audio PLL output; that PLL's lock output drives pll_locked.
- Derives MCLK (256fs = 12.288 MHz), SCLK (64fs = 3.072 MHz) and LRCLK (fs = 48 kHz) by division of clk.
- Serializes stereo PCM samples delivered over a valid/ready handshake into a one-entry holding buffer.
- Sits between the audio mixer/source and the external DAC/HDMI audio pins.

Parameters:
- WIDTH, 16, sample width per channel; legal range 8..24; MSB-first within a 32-bit slot, remaining slot bits zero.

Ports:
- clk  in  1  24.576 MHz audio clock (PLL output)
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk; synchronized internally
- sample_l  in  WIDTH  left sample, two's complement
- sample_r  in  WIDTH  right sample, two's complement
- sample_valid  in  1  sample pair offered
- sample_ready  out  1  holding buffer empty and block running
- mclk  out  1  clk/2
- sclk  out  1  clk/8
- lrclk  out  1  clk/512; 0 = left slot, 1 = right slot
- sdata  out  1  serial data; changes on SCLK falling edge
- underrun  out  1  one-cycle pulse, no sample available at frame load

Behaviour:
- Reset values: all outputs 0. Frame counter cnt[8:0] = 0, buffer empty, shift register 0, last-sample registers 0.
- Lock synchronizer: pll_locked passes through a 2-flop synchronizer to give run. While run = 0:
  - cnt is held at 0.
  - mclk, sclk, lrclk, sdata and sample_ready are forced to 0.
  - Buffer contents are discarded.
  - Operation resumes at cnt = 0 the cycle after run rises.
- Counter: cnt increments every cycle while run = 1 and wraps 511 -> 0.
- Clock outputs: all registered; mclk = cnt[0], sclk = cnt[2], lrclk = cnt[8], each delayed one cycle consistently with sdata.
- Bit position: p = cnt[7:3] (0..31) within the current slot.
- sdata update: occurs on the cycle where cnt[2:0] wraps 7 -> 0, aligned with sclk falling.
  - I2S one-bit delay: sdata = 0 for p = 0.
  - Bits WIDTH-1..0 of the slot sample for p = 1..WIDTH.
  - 0 for p > WIDTH.
- Handshake: sample_ready = run & buffer empty. Accept occurs when sample_valid & sample_ready at a rising clk edge; the buffer captures {sample_l, sample_r} and becomes full. No back-to-back acceptance while full.
- Frame load: happens on the cycle cnt = 511, so the new frame starts at cnt = 0.
  - Buffer full: shift/last registers load from the buffer; buffer empties.
  - Buffer empty with an accept in the same cycle: the incoming pair loads directly into the shift/last registers; buffer stays empty; no underrun.
  - Buffer empty with no accept: last pair repeats; underrun pulses high for one cycle (cnt = 0).
- Latency: a sample accepted before cnt = 511 appears as the MSB on sdata at left slot p = 1, i.e. 8 cycles after frame start, plus the output register delay.
- Reset mid-frame: all state clears asynchronously; on release the first frame starts cleanly at cnt = 0 with zero data.

Optional Feature:
- Macro AUDIO_I2S_LJ_EN.
- Defined: left-justified format.
  - Slot MSB at p = 0, bits at p = 0..WIDTH-1.
  - lrclk inverted: 1 = left slot.
- Undefined: standard I2S as described above.
- Clock dividers and handshake are identical in both builds.

Decomposition:
- Package audio_pkg holds:
  - FRAME_LEN = 512, SCLK_DIV = 8, SLOT_BITS = 32, MCLK_DIV = 2.
  - Typedef for the stereo sample pair struct (l, r).
- Sub-module audio_clk_gen holds the lock synchronizer, the frame counter and the registered mclk/sclk/lrclk outputs. It exports cnt, run and a frame_load strobe.
- The top holds the buffer, handshake and serializer.

Test Plan:
1. Reset and lock gating: assert rst, then release with pll_locked = 0 for 100 cycles -> all outputs remain 0, sample_ready = 0. Raise pll_locked -> outputs start toggling within 3 cycles.
2. Clock ratios: run 2048 cycles -> mclk period 2, sclk period 8, lrclk period 512 cycles, 64 sclk falls per lrclk period, exactly 50% duty on each.
3. Serialization: WIDTH = 16, offer L = 0xA5C3, R = 0x1234 -> sdata captured on sclk rising gives 0, 1010010111000011, then zeros in the left slot; 0, 0001001000110100, then zeros in the right slot.
4. Underrun: no sample offered for a frame -> underrun pulses once per frame at cnt = 0 and the previous pair repeats on sdata.
5. Boundary accept: buffer empty, sample_valid asserted exactly at cnt = 511 -> no underrun, and the pair appears in the immediately following frame.
6. Mid-frame reset: assert rst at cnt = 200 with the buffer full -> outputs 0 immediately, buffer empty after release. Same for a pll_locked drop. With AUDIO_I2S_LJ_EN defined, MSB appears at p = 0 and lrclk = 1 during the left slot.
